// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: shift-add multiply, restoring divide, then a sign fix-up stage.
// Optional build macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

   state_t              state;
   state_t              state_nx;
   logic [2:0]          op_q;
   logic [CNT_W-1:0]    cnt;
   logic                neg_res;
   logic                neg_rem;
   logic [2*XLEN-1:0]   mcand;
   logic [XLEN-1:0]     mplier;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     divisor;
   logic [XLEN-1:0]     rem;
   logic [XLEN-1:0]     quo;
   logic [XLEN-1:0]     result;

   logic                signed_a;
   logic                signed_b;
   logic                a_neg;
   logic                b_neg;
   logic [XLEN-1:0]     a_abs;
   logic [XLEN-1:0]     b_abs;
   logic                special;
   logic [XLEN-1:0]     special_val;
   logic                mul_finish;
   logic [XLEN:0]       shifted;
   logic [XLEN:0]       trial;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix;
   logic [XLEN-1:0]     rem_fix;
   logic [XLEN-1:0]     sign_sel;
   logic                accept;

   // Operand signedness: MULHSU takes a signed and b unsigned.
   always_comb begin
      signed_a = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
      signed_b = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
      a_neg    = signed_a && a_i[XLEN-1];
      b_neg    = signed_b && b_i[XLEN-1];
      a_abs    = a_neg ? -a_i : a_i;
      b_abs    = b_neg ? -b_i : b_i;
   end

   always_comb begin
      special     = 1'b0;
      special_val = '0;
      if (op_i[2] && (b_i == '0)) begin
         special     = 1'b1;
         special_val = op_i[1] ? a_i : '1;
      end else if (op_i[2] && !op_i[0] && (a_i == INT_MIN) && (b_i == '1)) begin
         special     = 1'b1;
         special_val = op_i[1] ? '0 : a_i;
      end
`ifdef MULDIV_EARLY_OUT_EN
      else if (!op_i[2] && (b_i == '0)) begin
         special     = 1'b1;
         special_val = '0;
      end
`endif
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign mul_finish = !op_q[2] && (mplier[XLEN-1:1] == '0);
`else
   assign mul_finish = 1'b0;
`endif

   assign accept = start_i && !flush_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: begin
            if (start_i) begin
               state_nx = special ? DONE : CALC;
            end else begin
               state_nx = IDLE;
            end
         end
         CALC: begin
            if ((cnt == CNT_W'(1)) || mul_finish) begin
               state_nx = SIGN;
            end
         end
         SIGN:    state_nx = DONE;
         default: state_nx = IDLE;
      endcase
      if (flush_i) begin
         state_nx = IDLE;
      end
   end

   // Restoring step: remainder stays below the divisor, so bit XLEN of trial is the borrow.
   assign shifted = {rem, quo[XLEN-1]};
   assign trial   = shifted - {1'b0, divisor};

   always_comb begin
      prod_fix = neg_res ? -prod : prod;
      quo_fix  = neg_res ? -quo : quo;
      rem_fix  = neg_rem ? -rem : rem;
      case (op_q)
         OP_MUL:                       sign_sel = prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: sign_sel = prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              sign_sel = quo_fix;
         default:                      sign_sel = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q    <= '0;
         cnt     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         mcand   <= '0;
         mplier  <= '0;
         prod    <= '0;
         divisor <= '0;
         rem     <= '0;
         quo     <= '0;
         result  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  op_q    <= op_i;
                  cnt     <= CNT_W'(XLEN);
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  mcand   <= {{XLEN{1'b0}}, a_abs};
                  mplier  <= b_abs;
                  prod    <= '0;
                  divisor <= b_abs;
                  rem     <= '0;
                  quo     <= a_abs;
                  if (special) begin
                     result <= special_val;
                  end
               end
            end
            CALC: begin
               if (!flush_i) begin
                  cnt <= cnt - CNT_W'(1);
                  if (op_q[2]) begin
                     if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                     end else begin
                        rem <= shifted[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                     end
                  end else begin
                     if (mplier[0]) begin
                        prod <= prod + mcand;
                     end
                     mcand  <= mcand << 1;
                     mplier <= mplier >> 1;
                  end
               end
            end
            SIGN: begin
               if (!flush_i) begin
                  result <= sign_sel;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o   = (state == CALC) || (state == SIGN);
   assign done_o   = (state == DONE);
   assign result_o = result;

endmodule
